// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a single-port synchronous RAM: streams write bursts into the RAM
// and read bursts out through a small skid buffer that hides the RAM's registered read latency.
module ram_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CNT_W     = ADDR_WIDTH + 1;
    localparam int BUF_DEPTH = 3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]      issue_left_reg, issue_left_next;
    logic [CNT_W-1:0]      pop_left_reg, pop_left_next;
    logic                  ram_we_reg, ram_we_next;
    logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_WIDTH-1:0] ram_din_reg, ram_din_next;
    // Two-stage tracker of an issued read: address on the RAM port, then data on ram_dout.
    logic                  addr_pend_reg, addr_pend_next;
    logic                  dout_pend_reg, dout_pend_next;

    logic [1:0]            head_reg, head_next;
    logic [1:0]            tail_reg, tail_next;
    logic [1:0]            count_reg, count_next;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  entry_we;

    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  pop;
    logic                  push;
    logic                  room;
    logic [2:0]            credit;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [CNT_W-1:0]      len_plus_one;

    assign cmd_ready = (state_reg == ST_IDLE) && !rst;
    assign wr_ready  = (state_reg == ST_WRITE);
    assign busy      = (state_reg != ST_IDLE);
    assign rd_valid  = (count_reg != 2'd0);
    assign rd_data   = buf_mem[head_reg];
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_din   = ram_din_reg;

    assign cmd_fire     = cmd_valid && cmd_ready;
    assign wr_fire      = wr_valid && wr_ready;
    assign pop          = rd_valid && rd_ready;
    assign push         = dout_pend_reg;
    assign addr_inc     = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_ONE;
    assign len_plus_one = {1'b0, cmd_len} + CNT_ONE;

    // Every buffered word plus every read still in the RAM pipe holds a slot; a same-cycle pop frees one.
    assign credit = {1'b0, count_reg} + {2'b00, addr_pend_reg} + {2'b00, dout_pend_reg};
    assign room   = credit < (3'd3 + {2'b00, pop});

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        issue_left_next = issue_left_reg;
        pop_left_next   = pop_left_reg;
        ram_we_next     = 1'b0;
        ram_addr_next   = ram_addr_reg;
        ram_din_next    = ram_din_reg;
        addr_pend_next  = 1'b0;
        dout_pend_next  = addr_pend_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next      = cmd_wr ? ST_WRITE : ST_READ;
                    addr_next       = cmd_addr;
                    issue_left_next = len_plus_one;
                    pop_left_next   = len_plus_one;
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    ram_we_next     = 1'b1;
                    ram_addr_next   = addr_reg;
                    ram_din_next    = wr_data;
                    addr_next       = addr_inc;
                    issue_left_next = issue_left_reg - CNT_ONE;
                    if (issue_left_reg == CNT_ONE) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if ((issue_left_reg != '0) && room) begin
                    ram_addr_next   = addr_reg;
                    addr_next       = addr_inc;
                    issue_left_next = issue_left_reg - CNT_ONE;
                    addr_pend_next  = 1'b1;
                end
                if (pop) begin
                    pop_left_next = pop_left_reg - CNT_ONE;
                    if (pop_left_reg == CNT_ONE) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = (tail_reg == 2'd2) ? 2'd0 : tail_reg + 2'd1;
        end
        if (pop) begin
            head_next = (head_reg == 2'd2) ? 2'd0 : head_reg + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (tail_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            issue_left_reg <= '0;
            pop_left_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_din_reg    <= '0;
            addr_pend_reg  <= 1'b0;
            dout_pend_reg  <= 1'b0;
            head_reg       <= 2'd0;
            tail_reg       <= 2'd0;
            count_reg      <= 2'd0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            issue_left_reg <= issue_left_next;
            pop_left_reg   <= pop_left_next;
            ram_we_reg     <= ram_we_next;
            ram_addr_reg   <= ram_addr_next;
            ram_din_reg    <= ram_din_next;
            addr_pend_reg  <= addr_pend_next;
            dout_pend_reg  <= dout_pend_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
        end
    end

    // Buffer contents need no reset: an entry is only read once count_reg covers it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (entry_we[i]) begin
                buf_mem[i] <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: a behavioural RAM sits on the RAM port, and a reference memory
// updated from the bench's own write stimulus supplies every expected read word.
module tb_ram_burst_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;
    int popped;
    bit pop;

    always #5 clk = ~clk;

    ram_burst_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Single-port synchronous RAM with registered read.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // fixed_base >= 0 gives data fixed_base, fixed_base+1, ...; otherwise random data.
    task automatic do_write(input logic [AW-1:0] addr, input int len, input int gap_pct,
                            input bit poke_cmd, input int fixed_base);
        int done;
        int cyc;
        int a;
        bit hs;
        logic [DW-1:0] d;
        done = 0;
        cyc  = 0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = addr;
        cmd_len   = AW'(len);
        check("wr_cmd_ready", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        check("wr_busy", busy, 1);
        while (done < len + 1) begin
            wr_valid = ($urandom_range(99) >= gap_pct);
            d = (fixed_base >= 0) ? DW'(fixed_base + done) : DW'($urandom);
            wr_data = d;
            if (poke_cmd && cyc == 1) begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b0;
            end
            check("wr_ready_in_burst", wr_ready, 1);
            check("cmd_ready_while_busy", cmd_ready, 0);
            hs = wr_valid;
            tick;
            cyc++;
            if (hs) begin
                a = (int'(addr) + done) % DEPTH;
                check("ram_we_on_hs", ram_we, 1);
                check("ram_addr", ram_addr, a);
                check("ram_din", ram_din, d);
                ref_mem[a] = d;
                done++;
            end else begin
                check("ram_we_no_hs", ram_we, 0);
            end
            if (cyc > 1000) begin
                check("wr_timeout_words", done, len + 1);
                break;
            end
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'b0;
        check("wr_end_busy", busy, 0);
        $display("write burst addr=%02h len=%0d cycles=%0d", addr, len, cyc);
    endtask

    // mode 0: rd_ready always high; 1: low 10 cycles then random; 2: random.
    task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
        int k;
        int first;
        int got;
        bit p;
        k = 0;
        first = -1;
        got = 0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = addr;
        cmd_len   = AW'(len);
        rd_ready  = (mode == 0);
        check("rd_cmd_ready", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        while (got < len + 1 && k < 2000) begin
            check("rd_ram_we_low", ram_we, 0);
            if (rd_valid === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    check("rd_first_latency", k, 3);
                end
                check("rd_data", rd_data, ref_mem[(int'(addr) + got) % DEPTH]);
            end else if (first >= 0 && mode == 0) begin
                check("rd_no_bubble", rd_valid, 1);
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k >= 10) ? 1'($urandom_range(1)) : 1'b0;
                default: rd_ready = 1'($urandom_range(1));
            endcase
            p = rd_valid && rd_ready;
            tick;
            k++;
            if (p) begin
                got++;
            end
        end
        check("rd_word_count", got, len + 1);
        rd_ready = 1'b0;
        check("rd_end_busy", busy, 0);
        check("rd_end_valid", rd_valid, 0);
        $display("read burst addr=%02h len=%0d cycles=%0d", addr, len, k);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) tick;
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_wr_ready", wr_ready, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_din", ram_din, 0);
        rst = 1'b0;
        #1;
        check("release_cmd_ready", cmd_ready, 1);

        // Fill the whole memory so every later read has known contents.
        do_write(7'h00, 127, 20, 1'b0, -1);

        // Wrapping write with fixed data, then immediate read-back.
        do_write(7'h7E, 3, 0, 1'b0, 8'hA1);
        do_read(7'h7E, 3, 0);

        // Full-depth read at one word per cycle.
        do_read(7'h00, 127, 0);

        // Stalled then randomly back-pressured read.
        do_read(AW'($urandom), 15, 1);

        // Gappy write with a command offered mid-burst, then read of the last word written.
        do_write(7'h40, 4, 50, 1'b1, -1);
        do_read(7'h44, 0, 0);

        // Reset in the middle of a read burst.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 7'h10;
        cmd_len   = 7'd40;
        rd_ready  = 1'b1;
        tick;
        cmd_valid = 1'b0;
        popped = 0;
        for (int k = 0; k < 6; k++) begin
            if (rd_valid === 1'b1) begin
                check("pre_reset_rd_data", rd_data, ref_mem[(16 + popped) % DEPTH]);
            end
            pop = rd_valid && rd_ready;
            tick;
            if (pop) begin
                popped++;
            end
        end
        rst = 1'b1;
        tick;
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_ram_addr", ram_addr, 0);
        check("midrst_ram_din", ram_din, 0);
        tick;
        rst = 1'b0;
        #1;
        check("midrst_release_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("post_rst_rd_valid", rd_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        rd_ready = 1'b0;
        $display("read burst addr=10 len=40 abandoned by reset after %0d words", popped);

        // Random mix of bursts.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(1) == 1) begin
                do_write(AW'($urandom), int'($urandom_range(20)), 30, 1'b0, -1);
            end else begin
                do_read(AW'($urandom), int'($urandom_range(20)), 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
